// File: rtl/weight_update_feeder.sv
// weight_update_feeder: streams one weight slice per depth index from a weight store to the CNN core on each update request
// Ports: clk/rst (sync, active-high); layer_start/layer_base load the store pointer while idle;
//   update_weight_ram/_addr/fm_depth/kernel_size describe a request; src_rd_* talk to the store;
//   weight_data/write_weight_data_addr/weight_wr_valid carry slices; weight_data_done and busy report progress.
// Option: define WEIGHT_FEEDER_ZERO_PAD_EN to zero kernel words outside the live kernel_size x kernel_size window.
module weight_update_feeder #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE_MAX = 3,
  parameter int PARA_KERNEL     = 2,
  parameter int WADDR_W         = 8,
  parameter int SRC_ADDR_W      = 12,
  parameter int DEPTH_W         = 5,
  localparam int KS = KERNEL_SIZE_MAX,
  localparam int SW = KS * KS * PARA_KERNEL * DATA_WIDTH,
  localparam int AW = WADDR_W * PARA_KERNEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  layer_start,
  input  logic [SRC_ADDR_W-1:0] layer_base,
  input  logic [DEPTH_W-1:0]    fm_depth,
  input  logic [3:0]            kernel_size,
  input  logic                  update_weight_ram,
  input  logic [AW-1:0]         update_weight_ram_addr,
  output logic                  src_rd_en,
  output logic [SRC_ADDR_W-1:0] src_rd_addr,
  input  logic [SW-1:0]         src_rd_data,
  output logic [SW-1:0]         weight_data,
  output logic [AW-1:0]         write_weight_data_addr,
  output logic                  weight_wr_valid,
  output logic                  weight_data_done,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t                state_q, state_d;
  logic [SRC_ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [DEPTH_W-1:0]    rd_cnt_q, rd_cnt_d, wr_cnt_q, depth_q, depth_d;
  logic [AW-1:0]         addr_q, addr_d, waddr_d;
  logic [3:0]            ks_q, ks_d;
  logic                  req_q, rd_v_q, start, idle_like;
  logic [SW-1:0]         wdata_d;
  assign idle_like        = state_q == IDLE || state_q == DONE;
  assign busy             = state_q == FETCH || state_q == DRAIN;
  assign weight_data_done = state_q == DONE;
  assign src_rd_addr      = src_ptr_q;
  // layer_start outranks a same-cycle request; in DONE only a rising request edge starts a new transfer
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    rd_cnt_d  = rd_cnt_q;
    depth_d   = depth_q;
    addr_d    = addr_q;
    ks_d      = ks_q;
    start     = 1'b0;
    src_rd_en = 1'b0;
    if (idle_like && layer_start) begin
      state_d   = IDLE;
      src_ptr_d = layer_base;
    end else if (update_weight_ram && (state_q == IDLE || (state_q == DONE && !req_q))) begin
      start    = 1'b1;
      depth_d  = fm_depth;
      addr_d   = update_weight_ram_addr;
      ks_d     = kernel_size;
      rd_cnt_d = '0;
      state_d  = fm_depth == '0 ? DONE : FETCH;
    end else if (state_q == FETCH) begin
      src_rd_en = 1'b1;
      src_ptr_d = src_ptr_q + SRC_ADDR_W'(1);
      rd_cnt_d  = rd_cnt_q + DEPTH_W'(1);
      state_d   = rd_cnt_d == depth_q ? DRAIN : FETCH;
    end else if (state_q == DRAIN) begin
      state_d = wr_cnt_q == depth_q ? DONE : DRAIN;
    end
  end
  // per-lane address arithmetic wraps inside each lane
  always_comb begin
    waddr_d = '0;
    for (int k = 0; k < PARA_KERNEL; k++)
      waddr_d[k*WADDR_W +: WADDR_W] = addr_q[k*WADDR_W +: WADDR_W] + WADDR_W'(wr_cnt_q);
  end
`ifdef WEIGHT_FEEDER_ZERO_PAD_EN
  always_comb begin
    wdata_d = src_rd_data;
    for (int k = 0; k < PARA_KERNEL; k++)
      for (int r = 0; r < KS; r++)
        for (int c = 0; c < KS; c++)
          if (r >= int'(ks_q) || c >= int'(ks_q)) wdata_d[((k*KS+r)*KS+c)*DATA_WIDTH +: DATA_WIDTH] = '0;
  end
`else
  logic unused_ks;
  assign unused_ks = ^ks_q;
  assign wdata_d   = src_rd_data;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= IDLE;
      src_ptr_q              <= '0;
      rd_cnt_q               <= '0;
      wr_cnt_q               <= '0;
      depth_q                <= '0;
      addr_q                 <= '0;
      ks_q                   <= '0;
      req_q                  <= 1'b0;
      rd_v_q                 <= 1'b0;
      weight_data            <= '0;
      write_weight_data_addr <= '0;
      weight_wr_valid        <= 1'b0;
    end else begin
      state_q         <= state_d;
      src_ptr_q       <= src_ptr_d;
      rd_cnt_q        <= rd_cnt_d;
      depth_q         <= depth_d;
      addr_q          <= addr_d;
      ks_q            <= ks_d;
      req_q           <= update_weight_ram;
      rd_v_q          <= src_rd_en;
      weight_wr_valid <= rd_v_q;
      wr_cnt_q        <= start ? '0 : wr_cnt_q + DEPTH_W'(rd_v_q);
      if (rd_v_q) begin
        weight_data            <= wdata_d;
        write_weight_data_addr <= waddr_d;
      end
    end
  end
endmodule
